data_bus_ctrl: RTL and testbench

DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

---
 rtl/data_bus_pkg.sv | 25 ++
 rtl/data_bus_ctrl_if.sv | 36 +++
 rtl/data_bus_settle_timer.sv | 36 +++
 rtl/data_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_data_bus_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_pkg.sv
// Shared types and default constants for the relay-style data bus controller.
// The state encoding and parameter defaults live here so every block agrees on them.
package data_bus_pkg;

    localparam int DEF_DATA_BUS_WIDTH = 8;
    localparam int DEF_NUM_SRC        = 9;
    localparam int DEF_NUM_DST        = 13;
    localparam int DEF_SETTLE_CYCLES  = 2;
    localparam int MAX_SETTLE_CYCLES  = 15;
    localparam int SETTLE_CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_LOAD    = 3'd3,
        ST_RELEASE = 3'd4
    } bus_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_bus_ctrl_if.sv
// Request handshake plus bus-side signals of the data bus controller.
// master = requester/bus environment, slave = controller.
interface data_bus_ctrl_if
    import data_bus_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
    parameter int NUM_SRC        = DEF_NUM_SRC,
    parameter int NUM_DST        = DEF_NUM_DST
);
    localparam int SRC_W = idx_width(NUM_SRC);
    localparam int DST_W = idx_width(NUM_DST);

    logic                              req_valid;
    logic                              req_ready;
    logic [SRC_W-1:0]                  req_src;
    logic [DST_W-1:0]                  req_dst;
    logic [NUM_SRC*DATA_BUS_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]                src_sel;
    logic [NUM_DST-1:0]                dst_load;
    logic [DATA_BUS_WIDTH-1:0]         bus_data;
    logic                              busy;
    logic                              xfer_done;
    logic                              err_bad_sel;
    logic                              err_clr;

    modport master (
        output req_valid, req_src, req_dst, src_data, err_clr,
        input  req_ready, src_sel, dst_load, bus_data, busy, xfer_done, err_bad_sel
    );

    modport slave (
        input  req_valid, req_src, req_dst, src_data, err_clr,
        output req_ready, src_sel, dst_load, bus_data, busy, xfer_done, err_bad_sel
    );

endinterface

// File: rtl/data_bus_settle_timer.sv
// Loadable down-counter that times the relay settle interval.
// Holds at zero; zero flag is combinational from the count register.
module data_bus_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (count && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/data_bus_ctrl.sv
// Single-master data bus sequencer: select a source, let relays settle,
// strobe one destination, then release the bus before the next transfer.
module data_bus_ctrl
    import data_bus_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
    parameter int NUM_SRC        = DEF_NUM_SRC,
    parameter int NUM_DST        = DEF_NUM_DST,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input logic           clk,
    input logic           rst,
    data_bus_ctrl_if.slave bif
);

    localparam int SRC_W = idx_width(NUM_SRC);
    localparam int DST_W = idx_width(NUM_DST);
    localparam int CNT_W = SETTLE_CNT_W;
    localparam int W     = DATA_BUS_WIDTH;

    // The first settle cycle is spent at count N-1, so SETTLE lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    bus_state_t       state_reg;
    bus_state_t       state_next;
    logic [SRC_W-1:0] src_idx_reg;
    logic [SRC_W-1:0] src_idx_next;
    logic [DST_W-1:0] dst_idx_reg;
    logic [DST_W-1:0] dst_idx_next;
    logic             err_reg;
    logic             err_next;

    logic             req_bad;
    logic             bad_sel;
    logic             timer_load;
    logic             timer_count;
    logic             timer_zero;
    logic             drive;
    logic             load_phase;

    logic [NUM_SRC-1:0] sel_vec;
    logic [NUM_DST-1:0] load_vec;
    logic [W-1:0]       slice_gated [NUM_SRC];
    logic [W-1:0]       bus_acc;

    assign req_bad = (int'(bif.req_src) >= NUM_SRC) || (int'(bif.req_dst) >= NUM_DST);

    always_comb begin
        state_next   = state_reg;
        src_idx_next = src_idx_reg;
        dst_idx_next = dst_idx_reg;
        timer_load   = 1'b0;
        timer_count  = 1'b0;
        bad_sel      = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bif.req_valid) begin
                    // A bad index is consumed here and never reaches the bus.
                    if (req_bad) begin
                        bad_sel = 1'b1;
                    end else begin
                        src_idx_next = bif.req_src;
                        dst_idx_next = bif.req_dst;
                        state_next   = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                if (SETTLE_CYCLES > 0) begin
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end else begin
                    state_next = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_next = ST_LOAD;
                end else begin
                    timer_count = 1'b1;
                end
            end
            ST_LOAD: begin
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Set has priority so an error arriving with a clear is not lost.
    always_comb begin
        err_next = err_reg;
        if (bif.err_clr) begin
            err_next = 1'b0;
        end
        if (bad_sel) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            src_idx_reg <= '0;
            dst_idx_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            src_idx_reg <= src_idx_next;
            dst_idx_reg <= dst_idx_next;
            err_reg     <= err_next;
        end
    end

    data_bus_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    assign drive      = (state_reg == ST_SELECT) || (state_reg == ST_SETTLE) ||
                        (state_reg == ST_LOAD);
    assign load_phase = (state_reg == ST_LOAD);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign sel_vec[gi]     = drive && (src_idx_reg == SRC_W'(gi));
            assign slice_gated[gi] = sel_vec[gi] ? bif.src_data[gi*W +: W] : '0;
        end
        for (gi = 0; gi < NUM_DST; gi++) begin : g_dst
            assign load_vec[gi] = load_phase && (dst_idx_reg == DST_W'(gi));
        end
    endgenerate

    // Wired-OR of the gated slices; an undriven bus reads as zero.
    always_comb begin
        bus_acc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bus_acc = bus_acc | slice_gated[i];
        end
    end

    assign bif.req_ready   = (state_reg == ST_IDLE);
    assign bif.busy        = (state_reg != ST_IDLE);
    assign bif.src_sel     = sel_vec;
    assign bif.dst_load    = load_vec;
    assign bif.bus_data    = bus_acc;
    assign bif.xfer_done   = load_phase;
    assign bif.err_bad_sel = err_reg;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: one instance with a 2-cycle settle and one with none.
// Stimulus pushes expected transfers; a negedge monitor pops and checks each transfer.
module tb_data_bus_ctrl;

    localparam int W  = 8;
    localparam int NS = 9;
    localparam int ND = 13;

    typedef struct {
        logic [NS-1:0] sel;
        logic [ND-1:0] load;
        logic [W-1:0]  bus;
        int            load_off;
        int            idle_lat;
        int            sel_cycles;
        bit            abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_bus_ctrl_if #(.DATA_BUS_WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND)) if0 ();
    data_bus_ctrl_if #(.DATA_BUS_WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND)) if1 ();

    data_bus_ctrl #(
        .DATA_BUS_WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND), .SETTLE_CYCLES(2)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bif (if0.slave)
    );

    data_bus_ctrl #(
        .DATA_BUS_WIDTH(W), .NUM_SRC(NS), .NUM_DST(ND), .SETTLE_CYCLES(0)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bif (if1.slave)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    bit   in_xfer [2];
    bit   cur_ok  [2];
    int   c0      [2];
    int   sel_cnt [2];
    exp_t cur     [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int id, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d_%s: got 0x%0h expected 0x%0h (cycle %0d)", id, nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [NS-1:0] sel, input logic [ND-1:0] load,
                                input logic [W-1:0] bus, input int lo, input int il,
                                input int sc, input bit ab);
        exp_t e;
        e.sel = sel; e.load = load; e.bus = bus;
        e.load_off = lo; e.idle_lat = il; e.sel_cycles = sc; e.abort = ab;
        return e;
    endfunction

    task automatic mon_step(input int id, input logic r, input logic busy, input logic done,
                            input logic [NS-1:0] sel, input logic [ND-1:0] ld,
                            input logic [W-1:0] bus, input logic rdy);
        if (r) begin
            check(id, "rst_dst_load", 32'(ld), 32'(0));
            in_xfer[id] = 1'b0;
            return;
        end
        if (!in_xfer[id]) begin
            if (!busy) begin
                check(id, "idle_dst_load", 32'(ld), 32'(0));
                check(id, "idle_src_sel", 32'(sel), 32'(0));
                return;
            end
            in_xfer[id] = 1'b1;
            c0[id]      = cyc;
            sel_cnt[id] = 0;
            cur_ok[id]  = 1'b0;
            if (id == 0 && q0.size() > 0) begin
                cur[id] = q0.pop_front();
                cur_ok[id] = 1'b1;
            end else if (id == 1 && q1.size() > 0) begin
                cur[id] = q1.pop_front();
                cur_ok[id] = 1'b1;
            end
            check(id, "xfer_expected", 32'(cur_ok[id]), 32'(1));
        end
        if (!cur_ok[id]) begin
            if (!busy) in_xfer[id] = 1'b0;
            return;
        end
        if (sel != '0) begin
            sel_cnt[id]++;
            check(id, "src_sel", 32'(sel), 32'(cur[id].sel));
            check(id, "bus_data", 32'(bus), 32'(cur[id].bus));
        end else begin
            check(id, "bus_undriven", 32'(bus), 32'(0));
        end
        if (done || ld != '0) begin
            check(id, "dst_load", 32'(ld), cur[id].abort ? 32'(0) : 32'(cur[id].load));
            check(id, "xfer_done", 32'(done), 32'(1));
            check(id, "load_offset", 32'(cyc - c0[id]), 32'(cur[id].load_off));
        end
        if (!busy) begin
            check(id, "idle_latency", 32'(cyc - c0[id]), 32'(cur[id].idle_lat));
            check(id, "sel_cycles", 32'(sel_cnt[id]), 32'(cur[id].sel_cycles));
            check(id, "ready_in_idle", 32'(rdy), 32'(1));
            in_xfer[id] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, rst, if0.busy, if0.xfer_done, if0.src_sel, if0.dst_load, if0.bus_data,
                 if0.req_ready);
        mon_step(1, rst, if1.busy, if1.xfer_done, if1.src_sel, if1.dst_load, if1.bus_data,
                 if1.req_ready);
    end

    function automatic logic rdy(input int id);
        return (id == 0) ? if0.req_ready : if1.req_ready;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [3:0] s,
                           input logic [3:0] d);
        if (id == 0) begin
            if0.req_valid = v; if0.req_src = s; if0.req_dst = d;
        end else begin
            if1.req_valid = v; if1.req_src = s; if1.req_dst = d;
        end
    endtask

    // Returns just after the edge on which the handshake completed.
    task automatic wait_hs(input int id);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy(id)) break;
        end
        check(id, "handshake_in_time", 32'(k < 50), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int id, input logic [31:0] err_exp);
        if (id == 0) begin
            check(0, "q_src_sel", 32'(if0.src_sel), 32'(0));
            check(0, "q_dst_load", 32'(if0.dst_load), 32'(0));
            check(0, "q_bus", 32'(if0.bus_data), 32'(0));
            check(0, "q_busy", 32'(if0.busy), 32'(0));
            check(0, "q_done", 32'(if0.xfer_done), 32'(0));
            check(0, "q_err", 32'(if0.err_bad_sel), err_exp);
        end else begin
            check(1, "q_src_sel", 32'(if1.src_sel), 32'(0));
            check(1, "q_dst_load", 32'(if1.dst_load), 32'(0));
            check(1, "q_bus", 32'(if1.bus_data), 32'(0));
            check(1, "q_busy", 32'(if1.busy), 32'(0));
            check(1, "q_done", 32'(if1.xfer_done), 32'(0));
            check(1, "q_err", 32'(if1.err_bad_sel), err_exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS*W-1:0] src_vals;
        src_vals = {8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'hA5, 8'h22, 8'h11};
        if0.src_data = src_vals; if1.src_data = src_vals;
        if0.err_clr = 1'b0;      if1.err_clr = 1'b0;
        set_req(0, 1'b0, 4'd0, 4'd0);
        set_req(1, 1'b0, 4'd0, 4'd0);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet(0, 32'(0));
        check_quiet(1, 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(0, "ready_after_rst", 32'(if0.req_ready), 32'(1));
        check(1, "ready_after_rst", 32'(if1.req_ready), 32'(1));
        @(posedge clk); #1;

        // C (0xA5) to A with 2-cycle settle
        q0.push_back(mk(9'h004, 13'h0001, 8'hA5, 3, 5, 4, 1'b0));
        set_req(0, 1'b1, 4'd2, 4'd0);
        wait_hs(0);
        set_req(0, 1'b0, 4'd0, 4'd0);

        // Zero settle: memory (0x99) to CCR, then src0 to dst0
        q1.push_back(mk(9'h100, 13'h1000, 8'h99, 1, 3, 2, 1'b0));
        set_req(1, 1'b1, 4'd8, 4'd12);
        wait_hs(1);
        q1.push_back(mk(9'h001, 13'h0001, 8'h11, 1, 3, 2, 1'b0));
        set_req(1, 1'b1, 4'd0, 4'd0);
        wait_hs(1);
        set_req(1, 1'b0, 4'd0, 4'd0);

        // Back-to-back on the settling instance
        q0.push_back(mk(9'h020, 13'h0080, 8'h66, 3, 5, 4, 1'b0));
        q0.push_back(mk(9'h001, 13'h0008, 8'h11, 3, 5, 4, 1'b0));
        set_req(0, 1'b1, 4'd5, 4'd7);
        wait_hs(0);
        set_req(0, 1'b1, 4'd0, 4'd3);
        wait_hs(0);
        set_req(0, 1'b0, 4'd0, 4'd0);

        // Indices wander while valid stays high; only captured values matter
        q0.push_back(mk(9'h002, 13'h0004, 8'h22, 3, 5, 4, 1'b0));
        q0.push_back(mk(9'h040, 13'h0200, 8'h77, 3, 5, 4, 1'b0));
        set_req(0, 1'b1, 4'd1, 4'd2);
        wait_hs(0);
        set_req(0, 1'b1, 4'd3, 4'd11);
        @(posedge clk);
        @(posedge clk); #1;
        set_req(0, 1'b1, 4'd6, 4'd9);
        wait_hs(0);
        set_req(0, 1'b0, 4'd0, 4'd0);

        // Out-of-range source
        set_req(0, 1'b1, 4'd9, 4'd0);
        wait_hs(0);
        set_req(0, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        check(0, "bad_src_err", 32'(if0.err_bad_sel), 32'(1));
        check(0, "bad_src_ready", 32'(if0.req_ready), 32'(1));
        check(0, "bad_src_busy", 32'(if0.busy), 32'(0));
        @(posedge clk); #1;
        if0.err_clr = 1'b1;
        @(posedge clk); #1;
        if0.err_clr = 1'b0;
        @(negedge clk);
        check(0, "err_cleared", 32'(if0.err_bad_sel), 32'(0));
        @(posedge clk); #1;

        // Bad destination together with a clear: set wins
        set_req(0, 1'b1, 4'd4, 4'd13);
        if0.err_clr = 1'b1;
        wait_hs(0);
        set_req(0, 1'b0, 4'd0, 4'd0);
        if0.err_clr = 1'b0;
        @(negedge clk);
        check(0, "set_beats_clr", 32'(if0.err_bad_sel), 32'(1));
        @(posedge clk); #1;

        set_req(1, 1'b1, 4'd0, 4'd15);
        wait_hs(1);
        set_req(1, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        check(1, "bad_dst_err", 32'(if1.err_bad_sel), 32'(1));
        check(1, "bad_dst_busy", 32'(if1.busy), 32'(0));
        @(posedge clk); #1;

        // Reset while settling: no load strobe may ever appear
        q0.push_back(mk(9'h008, 13'h0002, 8'h44, 3, 5, 4, 1'b1));
        set_req(0, 1'b1, 4'd3, 4'd1);
        wait_hs(0);
        set_req(0, 1'b0, 4'd0, 4'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet(0, 32'(0));
        check_quiet(1, 32'(0));
        check(0, "ready_after_abort", 32'(if0.req_ready), 32'(1));
        repeat (8) @(negedge clk);

        check(0, "queue_drained", 32'(q0.size()), 32'(0));
        check(1, "queue_drained", 32'(q1.size()), 32'(0));
        check(0, "no_open_xfer", 32'(in_xfer[0]), 32'(0));
        check(1, "no_open_xfer", 32'(in_xfer[1]), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
